// File: rtl/matrix_addr_pkg.sv
// -----------------------------------------------------------------------------
// matrix_addr_pkg
// Shared definitions for the matrix address streamer:
//   - default slot geometry (BLOCK_SIZE, NUM_BLOCKS, ADDR_WIDTH, DIM_WIDTH)
//   - traversal-mode enum (ROW_MAJOR / COL_MAJOR)
//   - streamer FSM state enum (IDLE / STREAM / FINISH)
// No ports (package).
// -----------------------------------------------------------------------------
package matrix_addr_pkg;

    localparam int BLOCK_SIZE_DEF = 1152;
    localparam int NUM_BLOCKS_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int DIM_WIDTH_DEF  = 8;

    typedef enum logic {
        ROW_MAJOR = 1'b0,
        COL_MAJOR = 1'b1
    } trav_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } stream_state_t;

endpackage

// File: rtl/matrix_base_lookup.sv
// -----------------------------------------------------------------------------
// matrix_base_lookup
// Combinational matrix slot ID -> BRAM base address (matrix_id * BLOCK_SIZE).
// Built as a constant table so no run-time multiplier is needed and any
// NUM_BLOCKS (power of two or not) works. IDs beyond NUM_BLOCKS-1 map to 0.
// Ports:
//   matrix_id  in   ID_WIDTH    slot number
//   base       out  ADDR_WIDTH  first element address of that slot
// -----------------------------------------------------------------------------
module matrix_base_lookup
    import matrix_addr_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ID_WIDTH   = $clog2(NUM_BLOCKS)
) (
    input  logic [ID_WIDTH-1:0]   matrix_id,
    output logic [ADDR_WIDTH-1:0] base
);

    always_comb begin
        base = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (matrix_id == ID_WIDTH'(i)) begin
                base = ADDR_WIDTH'(i * BLOCK_SIZE);
            end
        end
    end

endmodule

// File: rtl/matrix_address_streamer.sv
// -----------------------------------------------------------------------------
// matrix_address_streamer
// On an accepted start, latches a matrix slot, its dimensions and traversal
// mode, then streams one BRAM element address per cycle (row-major or
// column-major) to the BRAM read side.
//
// Handshake: addr/addr_last are transferred on a cycle where
// addr_valid && addr_ready. Once addr_valid is high it stays high, and addr
// and addr_last hold stable, until that transfer happens; addr_valid never
// depends combinationally on addr_ready.
//
// Optional feature (macro MATRIX_ADDR_BOUNDS_CHECK_EN): starts whose
// rows*cols exceeds BLOCK_SIZE or whose matrix_id >= NUM_BLOCKS are rejected
// with a one-cycle error+done pulse and the FSM stays in IDLE. Without the
// macro no check is made and error is tied low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        command strobe, honoured only in IDLE
//   matrix_id    slot, sampled on accepted start
//   rows, cols   dimensions, sampled on accepted start
//   col_major    0 = row-major, 1 = column-major, sampled on accepted start
//   busy         high while streaming
//   addr         element address (base + r*cols + c)
//   addr_valid   addr is valid
//   addr_ready   consumer accepts addr
//   addr_last    final address of the stream (qualified by addr_valid)
//   done         one-cycle completion pulse
//   error        one-cycle rejected-command pulse (optional feature)
// -----------------------------------------------------------------------------
module matrix_address_streamer
    import matrix_addr_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
    parameter int ID_WIDTH   = $clog2(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ID_WIDTH-1:0]   matrix_id,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic                  col_major,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  addr_last,
    output logic                  done,
    output logic                  error
);

    // Counters carry one extra bit so rows-1/cols-1 compares never wrap.
    localparam int CW = DIM_WIDTH + 1;

    stream_state_t         state, state_next;
    trav_mode_t            mode_q;
    logic [ADDR_WIDTH-1:0] base_q, offset_q, base_lookup;
    logic [DIM_WIDTH-1:0]  rows_q, cols_q;
    logic [CW-1:0]         r_q, c_q;
    logic                  zero_dim, reject, reject_q, accept;
    logic                  handshake, at_last_row, at_last_col;

    matrix_base_lookup #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_base_lookup (
        .matrix_id (matrix_id),
        .base      (base_lookup)
    );

    assign zero_dim = (rows == '0) || (cols == '0);

`ifdef MATRIX_ADDR_BOUNDS_CHECK_EN
    // The only multiply in the block; evaluated once per command, never
    // on the per-address path.
    logic [2*DIM_WIDTH-1:0] area;
    assign area   = {{DIM_WIDTH{1'b0}}, rows} * {{DIM_WIDTH{1'b0}}, cols};
    assign reject = start && (state == IDLE) &&
                    ((int'(area) > BLOCK_SIZE) || (int'(matrix_id) >= NUM_BLOCKS));
    assign error  = reject_q;
`else
    assign reject = 1'b0;
    assign error  = 1'b0;
`endif

    assign accept      = start && (state == IDLE) && !reject;
    assign handshake   = (state == STREAM) && addr_ready;
    assign at_last_row = (r_q == CW'(rows_q) - CW'(1));
    assign at_last_col = (c_q == CW'(cols_q) - CW'(1));
    assign addr        = base_q + offset_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            reject_q <= 1'b0;
        end else begin
            state    <= state_next;
            reject_q <= reject;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        addr_valid = 1'b0;
        addr_last  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = zero_dim ? FINISH : STREAM;
                end
            end
            STREAM: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                addr_last  = at_last_row && at_last_col;
                if (handshake && at_last_row && at_last_col) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A rejected command completes without ever leaving IDLE.
        if (reject_q) begin
            done = 1'b1;
        end
    end

    // Address datapath: offset tracks r*cols + c incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            offset_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            r_q      <= '0;
            c_q      <= '0;
            mode_q   <= ROW_MAJOR;
        end else if (accept) begin
            base_q   <= base_lookup;
            offset_q <= '0;
            rows_q   <= rows;
            cols_q   <= cols;
            r_q      <= '0;
            c_q      <= '0;
            mode_q   <= col_major ? COL_MAJOR : ROW_MAJOR;
        end else if (handshake) begin
            if (mode_q == ROW_MAJOR) begin
                offset_q <= offset_q + ADDR_WIDTH'(1);
                if (at_last_col) begin
                    c_q <= '0;
                    r_q <= r_q + CW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
            end else begin
                if (at_last_row) begin
                    // Top of the next column: offset = new c = old c + 1.
                    r_q      <= '0;
                    c_q      <= c_q + CW'(1);
                    offset_q <= ADDR_WIDTH'(c_q) + ADDR_WIDTH'(1);
                end else begin
                    r_q      <= r_q + CW'(1);
                    offset_q <= offset_q + ADDR_WIDTH'(cols_q);
                end
            end
        end
    end

endmodule

// File: doc/matrix_address_streamer.md
Name: matrix_address_streamer

Overview:
- Sequential successor to the combinational matrix-ID-to-base-address lookup in the matrix BRAM manager.
- On a start command, latches a matrix ID, dimensions and traversal mode, then streams one BRAM element address per cycle over a valid/ready handshake.
- Supports row-major and column-major (transpose-read) traversal.
- Sits between the operation controllers (transpose, multiply, UART dump) and the BRAM read port.

Parameters:
- BLOCK_SIZE, 1152, elements reserved per matrix slot.
- NUM_BLOCKS, 8, number of matrix slots.
- ADDR_WIDTH, 14, BRAM address width; must satisfy NUM_BLOCKS*BLOCK_SIZE <= 2**ADDR_WIDTH.
- DIM_WIDTH, 8, width of row/column counts.
- ID_WIDTH, $clog2(NUM_BLOCKS), matrix ID width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle command strobe; honoured only in IDLE.
- matrix_id  in  ID_WIDTH  target slot, sampled on accepted start.
- rows  in  DIM_WIDTH  row count, sampled on accepted start.
- cols  in  DIM_WIDTH  column count, sampled on accepted start.
- col_major  in  1  0 = row-major, 1 = column-major; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- addr  out  ADDR_WIDTH  element address.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr.
- addr_last  out  1  marks the final address of a stream; qualified by addr_valid.
- done  out  1  one-cycle pulse at stream completion.
- error  out  1  one-cycle pulse on a rejected command (optional feature only).

Behaviour:
- Reset: all outputs are 0, and the FSM is in IDLE. Reset is asynchronous and may occur mid-stream; it aborts the stream, and no done pulse is produced.
- FSM states: IDLE, STREAM, FINISH.
- IDLE:
  - A start with rows==0 or cols==0 goes to FINISH; no addresses are emitted.
  - Any other start latches the inputs, sets base = matrix_id*BLOCK_SIZE and goes to STREAM. busy rises in the next cycle.
- STREAM:
  - addr_valid is high on the first cycle after start.
  - A handshake occurs when addr_valid && addr_ready. Throughput is one address per cycle.
  - While addr_ready is low, addr, addr_valid and addr_last hold stable.
- Address generation:
  - addr = base + offset, where offset = r*cols + c.
  - Generation is multiplier-free. The base multiply happens once at start, via constant multiply or a lookup.
  - Row-major: offset increments by 1 per handshake. c wraps at cols-1; r then increments.
  - Column-major: offset increases by cols per handshake. At r==rows-1, r returns to 0, c increments and offset = c+1.
- addr_last is asserted with the element (rows-1, cols-1). A handshake on the last address goes to FINISH.
- FINISH: done=1 for one cycle and busy drops, then the FSM returns to IDLE.
- start while busy is ignored. No queueing.
- Width rules:
  - Offset and counter arithmetic use ADDR_WIDTH and DIM_WIDTH+1 bits, so no wrap occurs inside valid dimensions.
  - Without bounds checking, dimensions larger than the slot spill into the next slot's addresses. That is the caller's responsibility.

Optional Feature:
- Macro: MATRIX_ADDR_BOUNDS_CHECK_EN.
- When defined:
  - In IDLE, a start with rows*cols > BLOCK_SIZE, or matrix_id >= NUM_BLOCKS, is rejected.
  - A rejected start pulses error for one cycle and pulses done in the same cycle.
  - No addresses are emitted, and the FSM stays in IDLE.
- When undefined: no check is made, and error is tied to 0.

Decomposition:
- Package matrix_addr_pkg holds:
  - the BLOCK_SIZE/NUM_BLOCKS/ADDR_WIDTH defaults;
  - the traversal-mode enum (ROW_MAJOR, COL_MAJOR);
  - the FSM state enum.
- One sub-module, matrix_base_lookup: combinational matrix_id -> base address for arbitrary NUM_BLOCKS, instantiated once. The stream logic stays in the top.

Test Plan:
- id=2, rows=2, cols=3, row-major, ready held 1 -> addr 2304,2305,2306,2307,2308,2309 on consecutive cycles; addr_last only on 2309; done the cycle after.
- Same command, col_major=1 -> 2304,2307,2305,2308,2306,2309; addr_last on 2309.
- id=7, rows=1, cols=4, ready toggled 1,0,0,1,... -> 8064..8067 each held stable while ready=0; no address skipped or duplicated.
- rows=0, cols=5, start -> no addr_valid; done pulses one cycle after start; start re-pulsed while busy during a 3x3 stream -> ignored, stream unaffected.
- Assert rst_n=0 after the 2nd handshake of a 3x3 stream -> addr_valid, busy and done go to 0 immediately; after release, a new id=1, 1x1 start yields addr 1152 with addr_last.
- With MATRIX_ADDR_BOUNDS_CHECK_EN: rows=40, cols=40 (1600>1152) -> error and done pulse together, no addr_valid; with the macro undefined, the same command streams 1600 addresses.
